bram_arbiter: RTL and testbench

Two-port arbiter that shares the single-port `Bram` (one-cycle registered read) between a core-side requester (port A) and a loader/debug-side requester (port B). It accepts at most one request per cycle with round-robin fairness and an optional exclusive lock for port B. It drives the `Bram` enable/write/address/data pins and routes each response back to the issuing port one cycle after acceptance. It sits between the core memory stage, the UART program loader and the `Bram` instance.

---
 rtl/bram_arbiter.sv | 75 +++++++
 tb/tb_bram_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/bram_arbiter.sv
// bram_arbiter: round-robin two-port arbiter (A = core, B = loader/debug) sharing a single-port Bram
// Ports: clock, reset (async, active-low)
//        a_req_*/b_req_* : valid/ready/we/addr/wd request channels; a_resp_*/b_resp_* : valid/rd/err responses
//        b_lock          : while high only port B can be granted
//        bram_*          : en/we/addr/wd to the Bram, rd from it (one-cycle registered read)
module bram_arbiter #(
    parameter int unsigned BRAM_SIZE = 512
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        a_req_valid,
    output logic        a_req_ready,
    input  logic        a_req_we,
    input  logic [31:0] a_req_addr,
    input  logic [31:0] a_req_wd,
    output logic        a_resp_valid,
    output logic [31:0] a_resp_rd,
    output logic        a_resp_err,
    input  logic        b_req_valid,
    output logic        b_req_ready,
    input  logic        b_req_we,
    input  logic [31:0] b_req_addr,
    input  logic [31:0] b_req_wd,
    output logic        b_resp_valid,
    output logic [31:0] b_resp_rd,
    output logic        b_resp_err,
    input  logic        b_lock,
    output logic        bram_en,
    output logic        bram_we,
    output logic [31:0] bram_addr,
    output logic [31:0] bram_wd,
    input  logic [31:0] bram_rd
);
    logic        last_b, resp_pending, resp_port_b, resp_is_read, resp_err;
    logic        a_ok, b_ok, grant_a, grant_b, accept, sel_we, in_range;
    logic [31:0] sel_addr, sel_wd;
    // reset gates the requests so nothing is accepted while it is held
    assign a_ok     = reset & a_req_valid & ~b_lock;
    assign b_ok     = reset & b_req_valid;
    // on a conflict A wins only if B was granted last
    assign grant_a  = a_ok & (~b_ok | last_b);
    assign grant_b  = b_ok & ~grant_a;
    assign accept   = grant_a | grant_b;
    assign sel_we   = grant_a ? a_req_we : b_req_we;
    assign sel_addr = grant_a ? a_req_addr : b_req_addr;
    assign sel_wd   = grant_a ? a_req_wd : b_req_wd;
    assign in_range = sel_addr < BRAM_SIZE;
    assign a_req_ready = grant_a;
    assign b_req_ready = grant_b;
    assign bram_en   = accept & in_range;
    assign bram_we   = bram_en & sel_we;
    assign bram_addr = accept ? sel_addr : 32'd0;
    assign bram_wd   = accept ? sel_wd : 32'd0;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_b       <= 1'b1;
            resp_pending <= 1'b0;
            resp_port_b  <= 1'b0;
            resp_is_read <= 1'b0;
            resp_err     <= 1'b0;
        end else begin
            resp_pending <= accept;
            resp_port_b  <= grant_b;
            resp_is_read <= accept & ~sel_we & in_range;
            resp_err     <= accept & ~in_range;
            if (accept) last_b <= grant_b;
        end
    end
    assign a_resp_valid = resp_pending & ~resp_port_b;
    assign b_resp_valid = resp_pending & resp_port_b;
    assign a_resp_rd    = (a_resp_valid & resp_is_read) ? bram_rd : 32'd0;
    assign b_resp_rd    = (b_resp_valid & resp_is_read) ? bram_rd : 32'd0;
    assign a_resp_err   = a_resp_valid & resp_err;
    assign b_resp_err   = b_resp_valid & resp_err;
endmodule

// File: tb/tb_bram_arbiter.sv
// tb_bram_arbiter: directed self-checking bench for bram_arbiter with a behavioural Bram
module tb_bram_arbiter;
    logic        clock = 1'b0;
    logic        reset;
    logic        a_req_valid, a_req_ready, a_req_we, a_resp_valid, a_resp_err;
    logic [31:0] a_req_addr, a_req_wd, a_resp_rd;
    logic        b_req_valid, b_req_ready, b_req_we, b_resp_valid, b_resp_err;
    logic [31:0] b_req_addr, b_req_wd, b_resp_rd;
    logic        b_lock, bram_en, bram_we;
    logic [31:0] bram_addr, bram_wd, bram_rd;
    logic [31:0] mem [512];
    int          n_vec = 0;
    int          n_err = 0;

    bram_arbiter #(.BRAM_SIZE(512)) dut (
        .clock(clock), .reset(reset),
        .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_we(a_req_we),
        .a_req_addr(a_req_addr), .a_req_wd(a_req_wd), .a_resp_valid(a_resp_valid),
        .a_resp_rd(a_resp_rd), .a_resp_err(a_resp_err),
        .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_we(b_req_we),
        .b_req_addr(b_req_addr), .b_req_wd(b_req_wd), .b_resp_valid(b_resp_valid),
        .b_resp_rd(b_resp_rd), .b_resp_err(b_resp_err),
        .b_lock(b_lock), .bram_en(bram_en), .bram_we(bram_we),
        .bram_addr(bram_addr), .bram_wd(bram_wd), .bram_rd(bram_rd)
    );

    always #5 clock = ~clock;

    // word i initially holds 0xA0000000 + i
    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 32'hA000_0000 + i;
        bram_rd = 32'd0;
    end

    always @(posedge clock) begin
        if (bram_en) begin
            if (bram_we) mem[bram_addr[8:0]] <= bram_wd;
            else bram_rd <= mem[bram_addr[8:0]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic av, input logic awe, input logic [31:0] aaddr, input logic [31:0] awd,
                         input logic bv, input logic bwe, input logic [31:0] baddr, input logic [31:0] bwd);
        a_req_valid = av; a_req_we = awe; a_req_addr = aaddr; a_req_wd = awd;
        b_req_valid = bv; b_req_we = bwe; b_req_addr = baddr; b_req_wd = bwd;
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    logic        ea_v, eb_v;
    logic [31:0] ea_rd, eb_rd;

    initial begin
        reset = 1'b0;
        b_lock = 1'b0;
        drive(1, 0, 2, 0, 1, 0, 1, 0);
        #2;
        chk("rst_a_ready", a_req_ready, 0);
        chk("rst_b_ready", b_req_ready, 0);
        chk("rst_en", bram_en, 0);
        chk("rst_a_valid", a_resp_valid, 0);
        chk("rst_b_valid", b_resp_valid, 0);
        tick; tick;
        chk("rst_hold_en", bram_en, 0);
        chk("rst_hold_b_valid", b_resp_valid, 0);
        chk("rst_hold_a_rd", a_resp_rd, 0);
        reset = 1'b1;
        #1;
        chk("first_a_ready", a_req_ready, 1);
        chk("first_b_ready", b_req_ready, 0);
        chk("first_en", bram_en, 1);
        chk("first_addr", bram_addr, 2);
        tick;
        drive(1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0);
        #1;
        chk("first_resp_valid", a_resp_valid, 1);
        chk("first_resp_rd", a_resp_rd, 32'hA000_0002);
        chk("first_b_valid", b_resp_valid, 0);
        chk("wr_we", bram_we, 1);
        chk("wr_addr", bram_addr, 5);
        chk("wr_wd", bram_wd, 32'hDEADBEEF);
        tick;
        drive(1, 0, 5, 0, 0, 0, 0, 0);
        #1;
        chk("wr_ack_valid", a_resp_valid, 1);
        chk("wr_ack_rd", a_resp_rd, 0);
        chk("wr_ack_err", a_resp_err, 0);
        chk("rd5_en", bram_en, 1);
        chk("rd5_we", bram_we, 0);
        tick;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("rd5_valid", a_resp_valid, 1);
        chk("rd5_rd", a_resp_rd, 32'hDEADBEEF);
        chk("idle_en", bram_en, 0);
        chk("idle_addr", bram_addr, 0);
        tick;
        chk("resp_cleared", a_resp_valid, 0);
        // single B write makes B the last grantee so A leads the round robin
        drive(0, 0, 0, 0, 1, 1, 7, 32'h1234_5678);
        #1;
        chk("bw_ready", b_req_ready, 1);
        tick;
        ea_v = 0; eb_v = 1; ea_rd = 0; eb_rd = 0;
        for (int i = 0; i <= 6; i++) begin
            if (i < 6) drive(1, 0, 10 + i, 0, 1, 0, 20 + i, 0);
            else drive(0, 0, 0, 0, 0, 0, 0, 0);
            #1;
            chk("rr_a_valid", a_resp_valid, ea_v);
            chk("rr_b_valid", b_resp_valid, eb_v);
            chk("rr_a_rd", a_resp_rd, ea_rd);
            chk("rr_b_rd", b_resp_rd, eb_rd);
            if (i < 6) begin
                chk("rr_a_ready", a_req_ready, (i % 2) == 0);
                chk("rr_addr", bram_addr, (i % 2) == 0 ? 10 + i : 20 + i);
            end
            ea_v = (i % 2) == 0; eb_v = (i % 2) == 1;
            ea_rd = ea_v ? 32'hA000_0000 + 10 + i : 0;
            eb_rd = eb_v ? 32'hA000_0000 + 20 + i : 0;
            tick;
        end
        b_lock = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 30, 0, 1, 0, 40 + i, 0);
            #1;
            chk("lock_a_ready", a_req_ready, 0);
            chk("lock_b_ready", b_req_ready, 1);
            chk("lock_b_valid", b_resp_valid, i > 0);
            chk("lock_b_rd", b_resp_rd, i > 0 ? 32'hA000_0000 + 40 + i - 1 : 0);
            tick;
        end
        b_lock = 1'b0;
        drive(1, 0, 30, 0, 1, 0, 44, 0);
        #1;
        chk("unlock_a_ready", a_req_ready, 1);
        chk("unlock_b_ready", b_req_ready, 0);
        chk("unlock_b_rd", b_resp_rd, 32'hA000_002B);
        tick;
        drive(0, 0, 0, 0, 1, 0, 512, 0);
        #1;
        chk("unlock_a_rd", a_resp_rd, 32'hA000_001E);
        chk("oor512_ready", b_req_ready, 1);
        chk("oor512_en", bram_en, 0);
        tick;
        drive(0, 0, 0, 0, 1, 0, 32'hFFFF_FFFF, 0);
        #1;
        chk("oor512_valid", b_resp_valid, 1);
        chk("oor512_err", b_resp_err, 1);
        chk("oor512_rd", b_resp_rd, 0);
        chk("oormax_en", bram_en, 0);
        tick;
        drive(0, 0, 0, 0, 1, 0, 511, 0);
        #1;
        chk("oormax_err", b_resp_err, 1);
        chk("oormax_rd", b_resp_rd, 0);
        chk("top_en", bram_en, 1);
        tick;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("top_valid", b_resp_valid, 1);
        chk("top_err", b_resp_err, 0);
        chk("top_rd", b_resp_rd, 32'hA000_01FF);
        tick;
        // reset asserted before the accept edge drops the request entirely
        drive(1, 0, 3, 0, 0, 0, 0, 0);
        #1;
        chk("pre_rst_ready", a_req_ready, 1);
        reset = 1'b0;
        #1;
        chk("mid_rst_ready", a_req_ready, 0);
        chk("mid_rst_en", bram_en, 0);
        tick;
        chk("mid_rst_a_valid", a_resp_valid, 0);
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick;
        chk("post_rst_a_valid", a_resp_valid, 0);
        // reset landing while a response is showing clears it at once
        drive(1, 0, 4, 0, 0, 0, 0, 0);
        tick;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk("pend_valid", a_resp_valid, 1);
        reset = 1'b0;
        #1;
        chk("async_clr_valid", a_resp_valid, 0);
        chk("async_clr_rd", a_resp_rd, 0);
        tick;
        reset = 1'b1;
        drive(1, 0, 6, 0, 1, 0, 8, 0);
        #1;
        chk("rst_last_b_a_wins", a_req_ready, 1);
        tick;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
